// File: rtl/uart_sender_if.sv
// Byte-client <-> UART transmitter handshake bundle (datain/start in, tx/busy out).
interface uart_sender_if;
    logic [7:0] datain;
    logic       start;
    logic       tx;
    logic       busy;

    modport master (output datain, output start, input tx, input busy);
    modport slave  (input datain, input start, output tx, output busy);
endinterface

// File: rtl/uart_sender.sv
// UART transmitter, 8N1 frame on tx, one byte per accepted start request.
// Optional even-parity bit between data and stop: define SENDER_PARITY_EN.
module uart_sender #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD_RATE    = 9600,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic [7:0] datain,
    input  logic       start,
    input  logic       clk,
    input  logic       rstn,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [2:0]       r_bit_idx, w_bit_idx;
    logic [7:0]       r_shift, w_shift;
    logic             r_tx, w_tx;
    logic             r_busy, w_busy;
    logic             w_bit_end;
`ifdef SENDER_PARITY_EN
    logic             r_parity, w_parity;
`endif

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign tx        = r_tx;
    assign busy      = r_busy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
`ifdef SENDER_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_bit_idx <= w_bit_idx;
            r_shift   <= w_shift;
            r_tx      <= w_tx;
            r_busy    <= w_busy;
`ifdef SENDER_PARITY_EN
            r_parity  <= w_parity;
`endif
        end
    end

    // tx is registered one bit ahead: each boundary loads the next level so the
    // pin changes exactly on the bit edge with no combinational path from start.
    always_comb begin
        w_state   = r_state;
        w_cnt     = w_bit_end ? '0 : r_cnt + 1'b1;
        w_bit_idx = r_bit_idx;
        w_shift   = r_shift;
        w_tx      = r_tx;
        w_busy    = r_busy;
`ifdef SENDER_PARITY_EN
        w_parity  = r_parity;
`endif
        case (r_state)
            IDLE: begin
                w_tx   = 1'b1;
                w_busy = 1'b0;
                w_cnt  = '0;
                if (start && !r_busy) begin
                    w_state   = START;
                    w_shift   = datain;
                    w_bit_idx = '0;
                    w_tx      = 1'b0;
                    w_busy    = 1'b1;
`ifdef SENDER_PARITY_EN
                    w_parity  = ^datain;
`endif
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state = DATA;
                    w_tx    = r_shift[0];
                    w_shift = {1'b0, r_shift[7:1]};
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef SENDER_PARITY_EN
                        w_state = PARITY;
                        w_tx    = r_parity;
`else
                        w_state = STOP;
                        w_tx    = 1'b1;
`endif
                    end else begin
                        w_bit_idx = r_bit_idx + 3'd1;
                        w_tx      = r_shift[0];
                        w_shift   = {1'b0, r_shift[7:1]};
                    end
                end
            end
`ifdef SENDER_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state = STOP;
                    w_tx    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    w_state = IDLE;
                    w_tx    = 1'b1;
                    w_busy  = 1'b0;
                end
            end
            default: begin
                w_state = IDLE;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
                w_cnt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_sender.sv
// Self-checking bench for uart_sender: directed and random frames against a bit-list model.
module tb_uart_sender;

    localparam int unsigned CLK_FREQ  = 49_000_000;
    localparam int unsigned BAUD_RATE = 7_000_000;
    localparam int unsigned N         = CLK_FREQ / BAUD_RATE;

    logic clk = 1'b0;
    logic rstn;
    int   tests = 0;
    int   fails = 0;

    always #10 clk = ~clk;

    uart_sender_if u_if ();

    uart_sender #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .datain (u_if.datain),
        .start  (u_if.start),
        .clk    (clk),
        .rstn   (rstn),
        .tx     (u_if.tx),
        .busy   (u_if.busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Called at a negedge while the DUT is idle; leaves time at the negedge of the idle cycle.
    task automatic send_frame(input logic [7:0] d, input bit hold, input bit lockout);
        bit          exp_bits[$];
        int unsigned good;
        int unsigned busy_cyc = 0;
        int unsigned k = 0;

        exp_bits = {};
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
`ifdef SENDER_PARITY_EN
        exp_bits.push_back(^d);
`endif
        exp_bits.push_back(1'b1);

        u_if.datain = d;
        u_if.start  = 1'b1;
        for (int b = 0; b < exp_bits.size(); b++) begin
            good = 0;
            for (int c = 0; c < int'(N); c++) begin
                @(negedge clk);
                if (k == 0) chk("accept_latency", {30'd0, u_if.tx, u_if.busy}, 32'd1);
                k++;
                if (u_if.tx === exp_bits[b] && u_if.busy === 1'b1) good++;
                if (u_if.busy === 1'b1) busy_cyc++;
                if (k == 2 && !hold) u_if.start = 1'b0;
                if (lockout && k == 3 * N) begin
                    u_if.datain = 8'hFF;
                    u_if.start  = 1'b1;
                end
                if (lockout && k == 3 * N + 2 && !hold) u_if.start = 1'b0;
            end
            chk($sformatf("bit%0d_of_%02h", b, d), good, N);
        end
        @(negedge clk);
        chk($sformatf("idle_after_%02h", d), {30'd0, u_if.tx, u_if.busy}, 32'd2);
        chk($sformatf("busy_cycles_%02h", d), busy_cyc, exp_bits.size() * N);
    endtask

    initial begin
        int unsigned bad;
        logic [7:0]  rd;

        rstn        = 1'b0;
        u_if.datain = 8'h00;
        u_if.start  = 1'b0;

        #15;  chk("reset_tx_a", u_if.tx, 1);   chk("reset_busy_a", u_if.busy, 0);
        #85;  chk("reset_tx_b", u_if.tx, 1);   chk("reset_busy_b", u_if.busy, 0);
        #95;  chk("reset_tx_c", u_if.tx, 1);   chk("reset_busy_c", u_if.busy, 0);
        #6;   rstn = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (u_if.tx !== 1'b1 || u_if.busy !== 1'b0) bad++;
        end
        chk("idle_after_reset", bad, 0);

        send_frame(8'h4A, 1'b0, 1'b0);
        send_frame(8'h4A, 1'b0, 1'b1);
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            rd = 8'($urandom);
            send_frame(rd, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        u_if.datain = 8'h4A;
        u_if.start  = 1'b1;
        repeat (N + 2 * N + N / 2) @(negedge clk);
        u_if.start = 1'b0;
        chk("pre_reset_busy", u_if.busy, 1);
        rstn = 1'b0;
        #1;
        chk("abort_tx", u_if.tx, 1);
        chk("abort_busy", u_if.busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        repeat (12 * N) begin
            @(negedge clk);
            if (u_if.tx !== 1'b1 || u_if.busy !== 1'b0) bad++;
        end
        chk("no_resume_after_abort", bad, 0);

        send_frame(8'h4A, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
